multicycle_control_fsm: RTL and testbench

Main sequencer for the multi-cycle MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback states. In each state it drives every datapath select and enable, including MemToReg, which steers the register-file write-data mux between ALU_Out and Mem_Data_Reg. It sits between the instruction register opcode field, the memory ready line and all datapath muxes and write enables.

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/mc_ctrl_output_decode.sv | 73 +++++++
 rtl/multicycle_control_fsm.sv | 106 ++++++++++
 tb/tb_multicycle_control_fsm.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared state codes, opcodes and control-field encodings for the multi-cycle MIPS controller.
// Also defines the control-word struct that is passed between the FSM and its output decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_output_decode.sv
// Combinational map from the current FSM state (plus Mem_Ready) to the full datapath control word.
// Only FETCH and MEM_WRITE look at mem_ready; nop_done marks an unknown opcode retiring in DECODE.
module mc_ctrl_output_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   nop_done,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.instr_done = nop_done;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.ior_d      = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle MIPS datapath: state register, next-state logic and control outputs.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a HALT state with a sticky Illegal_Op flag.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Mem_Ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Instr_Done,
    output logic [3:0] State
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       Illegal_Op
`endif
);

    state_t state_q;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   nop_done;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign nop_done = 1'b0;
`else
    assign nop_done = (state_q == S_DECODE) && !is_known_op(Opcode);
`endif

    mc_ctrl_output_decode u_output_decode (
        .state     (state_q),
        .mem_ready (Mem_Ready),
        .nop_done  (nop_done),
        .ctrl      (ctrl)
    );

    // Reset forces every strobe low in the same cycle so an abandoned instruction never writes.
    assign ctrl_out    = reset ? '0 : ctrl;
    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign IorD        = ctrl_out.ior_d;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign IRWrite     = ctrl_out.ir_write;
    assign MemToReg    = ctrl_out.mem_to_reg;
    assign RegDst      = ctrl_out.reg_dst;
    assign RegWrite    = ctrl_out.reg_write;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ALUOp       = ctrl_out.alu_op;
    assign PCSource    = ctrl_out.pc_source;
    assign Instr_Done  = ctrl_out.instr_done;
    assign State       = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            Illegal_Op <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH:     if (Mem_Ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
                        OP_ADDI:      state_q <= S_ADDI_EXEC;
                        default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                            state_q    <= S_HALT;
                            Illegal_Op <= 1'b1;
`else
                            state_q    <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEM_ADDR:  state_q <= (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (Mem_Ready) state_q <= S_MEM_WB;
                S_MEM_WRITE: if (Mem_Ready) state_q <= S_FETCH;
                S_EXECUTE:   state_q <= S_ALU_WB;
                S_ADDI_EXEC: state_q <= S_ADDI_WB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_HALT:      state_q <= S_HALT;
`endif
                default:     state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a reference model pushes expected control words per cycle.
// Honours MC_CTRL_ILLEGAL_TRAP_EN so the same bench covers both the trap and the NOP build.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic       Mem_Ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, Instr_Done;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       Illegal_Op;
`endif

    typedef struct packed {
        logic [20:0] val;
        logic [20:0] mask;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [3:0]  m_state;
    int          checks;
    int          errors;

    multicycle_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .Mem_Ready   (Mem_Ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemToReg    (MemToReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .Instr_Done  (Instr_Done),
        .State       (State)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        .Illegal_Op  (Illegal_Op)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] observed();
        return {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Instr_Done};
    endfunction

    function automatic logic known(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08;
    endfunction

    // Reference control word written straight from the per-state output table.
    function automatic logic [20:0] model_out(input logic [3:0] s, input logic rdy,
                                              input logic [5:0] op, input logic rst);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done;
        logic [1:0] sb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, done} = '0;
        sb = 2'b00; aop = 2'b00; pcs = 2'b00;
        if (!rst) begin
            case (s)
                4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
                4'd1: begin
                    sb = 2'b11;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                    done = !known(op);
`endif
                end
                4'd2:  begin asa = 1; sb = 2'b10; end
                4'd3:  begin mr = 1; iord = 1; end
                4'd4:  begin m2r = 1; rw = 1; done = 1; end
                4'd5:  begin mw = 1; iord = 1; done = rdy; end
                4'd6:  begin asa = 1; aop = 2'b10; end
                4'd7:  begin rd = 1; rw = 1; done = 1; end
                4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
                4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
                4'd10: begin asa = 1; sb = 2'b10; end
                4'd11: begin rw = 1; done = 1; end
                default: ;
            endcase
        end
        return {s, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, sb, aop, pcs, done};
    endfunction

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic rdy, input logic [5:0] op);
        case (s)
            4'd0: return rdy ? 4'd1 : 4'd0;
            4'd1: begin
                case (op)
                    6'h23, 6'h2B: return 4'd2;
                    6'h00:        return 4'd6;
                    6'h04:        return 4'd8;
                    6'h02:        return 4'd9;
                    6'h08:        return 4'd10;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:      return 4'd12;
`else
                    default:      return 4'd0;
`endif
                endcase
            end
            4'd2:  return (op == 6'h23) ? 4'd3 : 4'd5;
            4'd3:  return rdy ? 4'd4 : 4'd3;
            4'd5:  return rdy ? 4'd0 : 4'd5;
            4'd6:  return 4'd7;
            4'd10: return 4'd11;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            4'd12: return 4'd12;
`endif
            default: return 4'd0;
        endcase
    endfunction

    // One cycle: drive inputs just after the edge, queue the expectation, land on the sampling edge.
    task automatic drive(input logic [5:0] op, input logic rdy, input logic rst);
        exp_t x;
        @(posedge clk);
        #1;
        Opcode    = op;
        Mem_Ready = rdy;
        reset     = rst;
        x.val  = model_out(m_state, rdy, op, rst);
        x.mask = rst ? 21'h01FFFF : 21'h1FFFFF;
        exp_q.push_back(x);
        m_state = rst ? 4'd0 : model_next(m_state, rdy, op);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int done_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(6'h23, 1'b1, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if ((observed() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc %0d got %h exp %h", i, observed() & e.mask, e.val & e.mask);
            end
        end
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(6'h23, (i < 5) ? 1'b1 : 1'b0, 1'b0);
            if (Instr_Done) done_cnt++;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("[TB] FAIL lw_after_reset cyc %0d got %h exp %h", i, observed(), e.val);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL lw_done_pulses got %0d exp 1", done_cnt);
        end
    endtask

    task automatic test_rtype();
        for (int i = 0; i < 4; i++) begin
            drive(6'h00, 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("[TB] FAIL rtype cyc %0d got %h exp %h", i, observed(), e.val);
            end
        end
    endtask

    task automatic test_lw_stall();
        logic rdy_seq [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   done_at;
        done_at = 0;
        for (int i = 0; i < 10; i++) begin
            drive(6'h23, rdy_seq[i], 1'b0);
            if (Instr_Done && done_at == 0) done_at = i + 1;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("[TB] FAIL lw_stall cyc %0d got %h exp %h", i, observed(), e.val);
            end
        end
        checks++;
        if (done_at !== 10) begin
            errors++;
            $display("[TB] FAIL lw_stall_latency got %0d exp 10", done_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7] = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h04, 6'h04, 6'h04};
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("[TB] FAIL sw_beq cyc %0d got %h exp %h", i, observed(), e.val);
            end
        end
    endtask

    task automatic test_addi_jump();
        logic [5:0] ops [7] = '{6'h08, 6'h08, 6'h08, 6'h08, 6'h02, 6'h02, 6'h02};
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("[TB] FAIL addi_j cyc %0d got %h exp %h", i, observed(), e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            drive(6'h23, 1'b1, (i == 4) ? 1'b1 : 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ((observed() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("[TB] FAIL reset_mid cyc %0d got %h exp %h", i, observed() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 7; i++) begin
            drive(6'h3F, 1'b0 | (i < 5), (i == 5) ? 1'b1 : 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ((observed() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("[TB] FAIL illegal_trap cyc %0d got %h exp %h", i, observed() & e.mask, e.val & e.mask);
            end
            checks++;
            if (Illegal_Op !== ((i >= 2 && i <= 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL illegal_flag cyc %0d got %b exp %b", i, Illegal_Op, (i >= 2 && i <= 5));
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            drive(6'h3F, (i < 2) ? 1'b1 : 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("[TB] FAIL illegal_nop cyc %0d got %h exp %h", i, observed(), e.val);
            end
        end
`endif
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        Opcode    = 6'h00;
        Mem_Ready = 1'b0;
        m_state   = 4'd0;
        checks    = 0;
        errors    = 0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_addi_jump();
        test_reset_mid();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
